// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: load/store controller in front of a 4-lane byte-write data
// memory with a 1-cycle registered read. Arbitrates round-robin between the
// core LSU (byte address, RV32 funct3) and a host loader/debug port (word
// address, raw strobes). Keeps one access in flight and sequences it as
// IDLE -> ISSUE -> (write) RESP | (read) WAIT -> RESP -> IDLE.
//
// Ports
//   clka, rsta               clock; synchronous active-low reset
//   core_req_*               core request (valid/ready handshake)
//   core_rsp_*               core response pulse, aligned/extended load data, error
//   host_req_*               host request (valid/ready handshake)
//   host_rsp_*               host response pulse, raw read word
//   dmem_wea/addra/dina      lane write enables, word address, write data to dmem
//   dmem_douta               dmem read data, valid one cycle after the address
//
// Build option: define DMEM_LSU_MISALIGN_TRAP_EN to make misaligned or illegal
// core accesses skip memory and answer with core_rsp_err=1. Without it,
// misaligned accesses are truncated to natural alignment and illegal funct3
// is executed as a word access.

`ifndef RV_BIT_NUM
`define RV_BIT_NUM 32
`endif
`ifndef RV_BIT_NUM_DIVIV_NUM
`define RV_BIT_NUM_DIVIV_NUM 4
`endif
`ifndef DMEMM_ADDR_BIT_NUM
`define DMEMM_ADDR_BIT_NUM 10
`endif

module dmem_lsu_ctrl #(
  parameter int XLEN   = `RV_BIT_NUM,
  parameter int LANES  = `RV_BIT_NUM_DIVIV_NUM,
  parameter int ADDR_W = `DMEMM_ADDR_BIT_NUM
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic              core_we,
  input  logic [2:0]        core_funct3,
  input  logic [31:0]       core_addr,
  input  logic [XLEN-1:0]   core_wdata,
  output logic              core_rsp_valid,
  output logic [XLEN-1:0]   core_rsp_data,
  output logic              core_rsp_err,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [LANES-1:0]  host_wstrb,
  input  logic [XLEN-1:0]   host_wdata,
  output logic              host_rsp_valid,
  output logic [XLEN-1:0]   host_rsp_data,
  output logic [LANES-1:0]  dmem_wea,
  output logic [ADDR_W-1:0] dmem_addra,
  output logic [XLEN-1:0]   dmem_dina,
  input  logic [XLEN-1:0]   dmem_douta
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t           state, state_nxt;
  logic             last_host, cur_host;
  logic             req_we, req_uns;
  size_t            req_size, dec_size;
  logic [1:0]       req_off, dec_off;
  logic [XLEN-1:0]  req_wdata;
  logic [LANES-1:0] req_wstrb;
  logic             dec_uns, dec_ill;
  logic             pick_core, pick_host, accept, skip;
  logic             rsp_fire;
  logic [XLEN-1:0]  rsp_word, ld_sh, ld_val, st_din;
  logic [LANES-1:0] st_wea;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^core_addr[31:ADDR_W+2];

  // Round-robin: on contention the port not granted last time wins.
  assign pick_core = core_req_valid && (!host_req_valid || last_host);
  assign pick_host = host_req_valid && !pick_core;
  assign accept    = (state == IDLE) && (pick_core || pick_host);

  // Core request decode; offset is pre-truncated to the access's natural alignment.
  always_comb begin
    dec_size = SZ_W;
    dec_uns  = 1'b0;
    dec_ill  = 1'b0;
    case (core_funct3)
      3'b000:  dec_size = SZ_B;
      3'b001:  dec_size = SZ_H;
      3'b010:  dec_size = SZ_W;
      3'b100:  begin dec_size = SZ_B; dec_uns = 1'b1; dec_ill = core_we; end
      3'b101:  begin dec_size = SZ_H; dec_uns = 1'b1; dec_ill = core_we; end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_size = SZ_W;
      dec_uns  = 1'b0;
    end
    case (dec_size)
      SZ_B:    dec_off = core_addr[1:0];
      SZ_H:    dec_off = {core_addr[1], 1'b0};
      default: dec_off = 2'b00;
    endcase
  end

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  logic dec_err, req_err;
  assign dec_err = dec_ill || ((dec_size == SZ_H) && core_addr[0]) ||
                   ((dec_size == SZ_W) && (core_addr[1:0] != 2'b00));
  always_ff @(posedge clka) begin
    if (!rsta)       req_err <= 1'b0;
    else if (accept) req_err <= pick_core && dec_err;
  end
  assign skip = !cur_host && req_err;
  always_ff @(posedge clka) begin
    if (!rsta)                      core_rsp_err <= 1'b0;
    else if (rsp_fire && !cur_host) core_rsp_err <= skip;
  end
`else
  assign skip         = 1'b0;
  assign core_rsp_err = 1'b0;
`endif

  // Store lanes and replicated store data.
  always_comb begin
    case (req_size)
      SZ_B:    begin st_wea = LANES'(1) << req_off; st_din = {LANES{req_wdata[7:0]}}; end
      SZ_H:    begin st_wea = LANES'(3) << req_off; st_din = {(LANES/2){req_wdata[15:0]}}; end
      default: begin st_wea = '1;                  st_din = req_wdata; end
    endcase
    if (cur_host) begin
      st_wea = req_wstrb;
      st_din = req_wdata;
    end
  end

  // Load alignment and extension; host reads return the raw word.
  always_comb begin
    ld_sh = dmem_douta >> {req_off, 3'b000};
    case (req_size)
      SZ_B:    ld_val = req_uns ? {{(XLEN-8){1'b0}}, ld_sh[7:0]}
                                : {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
      SZ_H:    ld_val = req_uns ? {{(XLEN-16){1'b0}}, ld_sh[15:0]}
                                : {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      default: ld_val = ld_sh;
    endcase
    if (cur_host) ld_val = dmem_douta;
  end

  always_ff @(posedge clka) begin
    if (!rsta) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    core_req_ready = 1'b0;
    host_req_ready = 1'b0;
    dmem_wea       = '0;
    dmem_dina      = '0;
    rsp_fire       = 1'b0;
    rsp_word       = '0;
    case (state)
      IDLE: begin
        core_req_ready = pick_core;
        host_req_ready = pick_host;
        if (pick_core || pick_host) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (skip) begin
          state_nxt = RESP;
          rsp_fire  = 1'b1;
        end else if (req_we) begin
          dmem_wea  = st_wea;
          dmem_dina = st_din;
          state_nxt = RESP;
          rsp_fire  = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        state_nxt = RESP;
        rsp_fire  = 1'b1;
        rsp_word  = ld_val;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset kills the write strobe immediately so an in-flight store never lands.
    if (!rsta) begin
      dmem_wea       = '0;
      core_req_ready = 1'b0;
      host_req_ready = 1'b0;
    end
  end

  always_ff @(posedge clka) begin
    if (!rsta) begin
      last_host  <= 1'b1;
      cur_host   <= 1'b0;
      req_we     <= 1'b0;
      req_uns    <= 1'b0;
      req_size   <= SZ_W;
      req_off    <= 2'b00;
      req_wdata  <= '0;
      req_wstrb  <= '0;
      dmem_addra <= '0;
    end else if (accept) begin
      cur_host  <= pick_host;
      last_host <= pick_host;
      if (pick_host) begin
        req_we     <= host_we;
        req_uns    <= 1'b0;
        req_size   <= SZ_W;
        req_off    <= 2'b00;
        req_wdata  <= host_wdata;
        req_wstrb  <= host_wstrb;
        dmem_addra <= host_addr;
      end else begin
        req_we     <= core_we;
        req_uns    <= dec_uns;
        req_size   <= dec_size;
        req_off    <= dec_off;
        req_wdata  <= core_wdata;
        req_wstrb  <= '0;
        dmem_addra <= core_addr[ADDR_W+1:2];
      end
    end
  end

  always_ff @(posedge clka) begin
    if (!rsta) begin
      core_rsp_valid <= 1'b0;
      core_rsp_data  <= '0;
      host_rsp_valid <= 1'b0;
      host_rsp_data  <= '0;
    end else begin
      core_rsp_valid <= 1'b0;
      host_rsp_valid <= 1'b0;
      if (rsp_fire) begin
        if (cur_host) begin
          host_rsp_valid <= 1'b1;
          host_rsp_data  <= rsp_word;
        end else begin
          core_rsp_valid <= 1'b1;
          core_rsp_data  <= rsp_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
module tb_dmem_lsu_ctrl;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic        has_exp;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        chk_lane;
    logic [3:0]  wea_exp;
    logic [31:0] dina_exp;
  } req_t;

  logic        clk = 1'b0;
  logic        rsta;
  logic        core_req_valid, core_req_ready, core_we;
  logic [2:0]  core_funct3;
  logic [31:0] core_addr, core_wdata, core_rsp_data;
  logic        core_rsp_valid, core_rsp_err;
  logic        host_req_valid, host_req_ready, host_we;
  logic [9:0]  host_addr;
  logic [3:0]  host_wstrb;
  logic [31:0] host_wdata, host_rsp_data;
  logic        host_rsp_valid;
  logic [3:0]  dmem_wea;
  logic [9:0]  dmem_addra;
  logic [31:0] dmem_dina, dmem_douta;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] dmem [0:1023] = '{default: '0};
  logic [7:0]  ref_mem [0:4095] = '{default: '0};
  bit          m_last_host = 1'b1;
  req_t        core_q[$];
  req_t        host_q[$];
  bit          grant_log[$];

  always #5 clk = ~clk;

  dmem_lsu_ctrl #(.XLEN(32), .LANES(4), .ADDR_W(10)) dut (
    .clka(clk), .rsta(rsta),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_we(core_we), .core_funct3(core_funct3), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rsp_valid(core_rsp_valid),
    .core_rsp_data(core_rsp_data), .core_rsp_err(core_rsp_err),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_we(host_we), .host_addr(host_addr), .host_wstrb(host_wstrb),
    .host_wdata(host_wdata), .host_rsp_valid(host_rsp_valid),
    .host_rsp_data(host_rsp_data), .dmem_wea(dmem_wea),
    .dmem_addra(dmem_addra), .dmem_dina(dmem_dina), .dmem_douta(dmem_douta)
  );

  // Byte-lane data memory with a registered read port.
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++)
      if (dmem_wea[j]) dmem[dmem_addra][8*j +: 8] <= dmem_dina[8*j +: 8];
    dmem_douta <= dmem[dmem_addra];
  end

  function automatic req_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] strb,
                              input logic has_exp, input logic [31:0] exp_data);
    req_t r;
    r.we = we; r.f3 = f3; r.addr = addr; r.wd = wd; r.strb = strb;
    r.has_exp = has_exp; r.exp_data = exp_data; r.exp_err = 1'b0;
    r.chk_lane = 1'b0; r.wea_exp = 4'h0; r.dina_exp = 32'h0;
    return r;
  endfunction

  // Byte-addressed reference: an access covers `size` bytes starting at the
  // naturally aligned base address.
  function automatic void model_core(input req_t r, output logic [31:0] d, output logic e,
                                     output logic [3:0] w, output logic [31:0] di, output int lat);
    int size, base;
    bit uns, ill, mis;
    size = 4; uns = 0; ill = 0;
    case (r.f3)
      3'b000: size = 1;
      3'b001: size = 2;
      3'b010: size = 4;
      3'b100: begin size = 1; uns = 1; ill = r.we; end
      3'b101: begin size = 2; uns = 1; ill = r.we; end
      default: ill = 1;
    endcase
    if (ill) begin size = 4; uns = 0; end
    mis = (int'(r.addr[1:0]) % size) != 0;
    d = '0; e = 1'b0; w = '0; di = '0; lat = 2;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    if (ill || mis) begin e = 1'b1; return; end
`else
    if (mis) e = 1'b0;
`endif
    base = int'(r.addr[11:0]) - (int'(r.addr[11:0]) % size);
    if (r.we) begin
      for (int i = 0; i < size; i++) begin
        ref_mem[base + i] = r.wd[8*i +: 8];
        w[(base + i) % 4] = 1'b1;
      end
      for (int j = 0; j < 4; j++) di[8*j +: 8] = r.wd[8*(j % size) +: 8];
    end else begin
      for (int i = 0; i < size; i++) d[8*i +: 8] = ref_mem[base + i];
      if (!uns && size < 4 && d[8*size - 1])
        for (int i = size; i < 4; i++) d[8*i +: 8] = 8'hFF;
      lat = 3;
    end
  endfunction

  function automatic void model_host(input req_t r, output logic [31:0] d, output logic [3:0] w,
                                     output logic [31:0] di, output int lat);
    int base;
    base = int'(r.addr[9:0]) * 4;
    d = '0; w = '0; di = '0; lat = 2;
    if (r.we) begin
      for (int j = 0; j < 4; j++) if (r.strb[j]) ref_mem[base + j] = r.wd[8*j +: 8];
      w = r.strb; di = r.wd;
    end else begin
      for (int j = 0; j < 4; j++) d[8*j +: 8] = ref_mem[base + j];
      lat = 3;
    end
  endfunction

  // Drains core_q/host_q through the DUT, checking handshake, arbitration,
  // lane strobes, response timing and data cycle by cycle.
  task automatic run_traffic(input bit both_always, input int budget);
    int cyc = 0, issue_cyc = 0, rsp_cyc = 0, lat = 0;
    bit pend = 0, pend_host = 0, c_act = 0, h_act = 0, idle;
    bit exp_cv, exp_hv, exp_cw, exp_hw;
    req_t cr, hr, pr;
    logic [31:0] e_d = '0, e_di = '0;
    logic e_e = 1'b0;
    logic [3:0] e_w = '0, w_exp;
    cr = mk(0, 0, 0, 0, 0, 0, 0); hr = cr; pr = cr;
    while ((core_q.size() != 0 || host_q.size() != 0 || c_act || h_act || pend) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      idle = !pend;
      w_exp = (pend && cyc == issue_cyc) ? e_w : 4'h0;
      n_vec++;
      if (dmem_wea !== w_exp) begin
        n_err++; $display("FAIL dmem_wea cyc %0d: got %b expected %b", cyc, dmem_wea, w_exp);
      end
      if (pend && cyc == issue_cyc && e_w != 4'h0) begin
        n_vec++;
        if (dmem_dina !== e_di) begin
          n_err++; $display("FAIL dmem_dina: got %h expected %h", dmem_dina, e_di);
        end
      end
      exp_cv = pend && !pend_host && cyc == rsp_cyc;
      exp_hv = pend && pend_host && cyc == rsp_cyc;
      n_vec++;
      if (core_rsp_valid !== exp_cv) begin
        n_err++; $display("FAIL core_rsp_valid cyc %0d: got %b expected %b", cyc, core_rsp_valid, exp_cv);
      end
      n_vec++;
      if (host_rsp_valid !== exp_hv) begin
        n_err++; $display("FAIL host_rsp_valid cyc %0d: got %b expected %b", cyc, host_rsp_valid, exp_hv);
      end
      if (exp_cv) begin
        n_vec++;
        if (core_rsp_data !== e_d || core_rsp_err !== e_e) begin
          n_err++; $display("FAIL core_rsp: got %h/%b expected %h/%b", core_rsp_data, core_rsp_err, e_d, e_e);
        end
        if (pr.has_exp) begin
          n_vec++;
          if (core_rsp_data !== pr.exp_data || core_rsp_err !== pr.exp_err) begin
            n_err++; $display("FAIL core_rsp_const: got %h/%b expected %h/%b",
                              core_rsp_data, core_rsp_err, pr.exp_data, pr.exp_err);
          end
        end
      end
      if (exp_hv) begin
        n_vec++;
        if (host_rsp_data !== e_d) begin
          n_err++; $display("FAIL host_rsp_data: got %h expected %h", host_rsp_data, e_d);
        end
        if (pr.has_exp) begin
          n_vec++;
          if (host_rsp_data !== pr.exp_data) begin
            n_err++; $display("FAIL host_rsp_const: got %h expected %h", host_rsp_data, pr.exp_data);
          end
        end
      end
      if (pend && cyc == rsp_cyc) pend = 0;

      if (!c_act && core_q.size() != 0 && (both_always || $urandom_range(1, 0) == 1)) begin
        cr = core_q.pop_front(); c_act = 1;
      end
      if (!h_act && host_q.size() != 0 && (both_always || $urandom_range(1, 0) == 1)) begin
        hr = host_q.pop_front(); h_act = 1;
      end
      core_req_valid = c_act; core_we = cr.we; core_funct3 = cr.f3;
      core_addr = cr.addr; core_wdata = cr.wd;
      host_req_valid = h_act; host_we = hr.we; host_addr = hr.addr[9:0];
      host_wstrb = hr.strb; host_wdata = hr.wd;
      #1;
      exp_cw = idle && c_act && (!h_act || m_last_host);
      exp_hw = idle && h_act && !exp_cw;
      n_vec++;
      if (core_req_ready !== exp_cw || host_req_ready !== exp_hw) begin
        n_err++; $display("FAIL ready cyc %0d: got core %b host %b expected core %b host %b",
                          cyc, core_req_ready, host_req_ready, exp_cw, exp_hw);
      end
      if (exp_cw) begin
        model_core(cr, e_d, e_e, e_w, e_di, lat);
        if (cr.chk_lane) begin e_w = cr.wea_exp; e_di = cr.dina_exp; end
        pr = cr; pend = 1; pend_host = 0; c_act = 0; m_last_host = 0;
        issue_cyc = cyc + 1; rsp_cyc = cyc + lat; grant_log.push_back(1'b0);
      end else if (exp_hw) begin
        model_host(hr, e_d, e_w, e_di, lat);
        e_e = 1'b0;
        pr = hr; pend = 1; pend_host = 1; h_act = 0; m_last_host = 1;
        issue_cyc = cyc + 1; rsp_cyc = cyc + lat; grant_log.push_back(1'b1);
      end
    end
    n_vec++;
    if (core_q.size() != 0 || host_q.size() != 0 || c_act || h_act || pend) begin
      n_err++; $display("FAIL traffic_timeout: got %0d cycles without completion, required completion", cyc);
      core_q.delete(); host_q.delete();
    end
    core_req_valid = 1'b0; host_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rsta = 1'b0;
    core_req_valid = 1'b1; host_req_valid = 1'b1;
    core_we = 1'b1; core_funct3 = 3'b010; core_addr = 32'h4; core_wdata = 32'h1;
    host_we = 1'b1; host_addr = 10'h1; host_wstrb = 4'hF; host_wdata = 32'h2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (core_req_ready !== 1'b0 || host_req_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got %b%b expected 00", core_req_ready, host_req_ready);
    end
    n_vec++;
    if (core_rsp_valid !== 1'b0 || host_rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_rsp_valid: got %b%b expected 00", core_rsp_valid, host_rsp_valid);
    end
    n_vec++;
    if (core_rsp_data !== 32'h0 || host_rsp_data !== 32'h0 || core_rsp_err !== 1'b0) begin
      n_err++; $display("FAIL reset_rsp_data: got %h %h %b expected 0", core_rsp_data, host_rsp_data, core_rsp_err);
    end
    n_vec++;
    if (dmem_wea !== 4'h0 || dmem_addra !== 10'h0 || dmem_dina !== 32'h0) begin
      n_err++; $display("FAIL reset_dmem: got %b %h %h expected 0", dmem_wea, dmem_addra, dmem_dina);
    end
    core_req_valid = 1'b0; host_req_valid = 1'b0;
    rsta = 1'b1;
    m_last_host = 1'b1;
  endtask

  task automatic test_core_directed();
    req_t r;
    r = mk(1, 3'b000, 32'h6, 32'h000000AB, 0, 1, 32'h0);
    r.chk_lane = 1'b1; r.wea_exp = 4'b0100; r.dina_exp = 32'hABABABAB;
    core_q.push_back(r);
    core_q.push_back(mk(0, 3'b000, 32'h6, 0, 0, 1, 32'hFFFFFFAB));
    core_q.push_back(mk(0, 3'b100, 32'h6, 0, 0, 1, 32'h000000AB));
    core_q.push_back(mk(1, 3'b010, 32'h8, 32'h12345678, 0, 1, 32'h0));
    core_q.push_back(mk(0, 3'b001, 32'hA, 0, 0, 1, 32'h00001234));
    core_q.push_back(mk(0, 3'b101, 32'h8, 0, 0, 1, 32'h00005678));
    run_traffic(1'b1, 500);
  endtask

  task automatic test_host();
    host_q.push_back(mk(1, 0, 32'h3, 32'h0, 4'hF, 1, 32'h0));
    host_q.push_back(mk(1, 0, 32'h3, 32'hDEADBEEF, 4'b0011, 1, 32'h0));
    host_q.push_back(mk(0, 0, 32'h3, 0, 0, 1, 32'h0000BEEF));
    run_traffic(1'b1, 500);
  endtask

  task automatic test_contention();
    test_reset();
    grant_log.delete();
    for (int i = 0; i < 5; i++) begin
      core_q.push_back(mk(1'($urandom_range(1, 0)), 3'b010, 32'($urandom_range(15, 0)) << 2,
                          $urandom, 0, 0, 0));
      host_q.push_back(mk(1'($urandom_range(1, 0)), 0, 32'($urandom_range(15, 0)),
                          $urandom, 4'($urandom_range(15, 0)), 0, 0));
    end
    run_traffic(1'b1, 1000);
    n_vec++;
    if (grant_log.size() != 10) begin
      n_err++; $display("FAIL grant_count: got %0d expected 10", grant_log.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_vec++;
        if (grant_log[i] != (i % 2 == 1)) begin
          n_err++; $display("FAIL grant_order[%0d]: got %0d expected %0d", i, grant_log[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    core_q.push_back(mk(1, 3'b010, 32'h10, 32'h55AA55AA, 0, 1, 32'h0));
    run_traffic(1'b1, 500);
    @(negedge clk);
    core_req_valid = 1'b1; core_we = 1'b1; core_funct3 = 3'b010;
    core_addr = 32'h10; core_wdata = 32'hFFFFFFFF;
    #1;
    n_vec++;
    if (core_req_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_accept: got %b expected 1", core_req_ready);
    end
    @(negedge clk);
    n_vec++;
    if (dmem_wea !== 4'hF) begin
      n_err++; $display("FAIL mid_issue_wea: got %b expected 1111", dmem_wea);
    end
    core_req_valid = 1'b0;
    rsta = 1'b0;
    #1;
    n_vec++;
    if (dmem_wea !== 4'h0) begin
      n_err++; $display("FAIL mid_reset_wea: got %b expected 0000", dmem_wea);
    end
    @(negedge clk);
    rsta = 1'b1;
    m_last_host = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (core_rsp_valid !== 1'b0 || host_rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL mid_no_rsp: got %b%b expected 00", core_rsp_valid, host_rsp_valid);
      end
      @(negedge clk);
    end
    core_q.push_back(mk(0, 3'b010, 32'h10, 0, 0, 1, 32'h55AA55AA));
    run_traffic(1'b1, 500);
  endtask

  task automatic test_misalign();
    req_t r;
    core_q.push_back(mk(1, 3'b010, 32'h0, 32'hCAFEF00D, 0, 1, 32'h0));
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    r = mk(0, 3'b010, 32'h2, 0, 0, 1, 32'h0);
    r.exp_err = 1'b1;
`else
    r = mk(0, 3'b010, 32'h2, 0, 0, 1, 32'hCAFEF00D);
`endif
    core_q.push_back(r);
    run_traffic(1'b1, 500);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      core_q.push_back(mk(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)),
                          32'($urandom_range(31, 0)), $urandom, 0, 0, 0));
    for (int i = 0; i < 20; i++)
      host_q.push_back(mk(1'($urandom_range(1, 0)), 0, 32'($urandom_range(7, 0)),
                          $urandom, 4'($urandom_range(15, 0)), 0, 0));
    run_traffic(1'b0, 3000);
  endtask

  initial begin
    rsta = 1'b0;
    core_req_valid = 1'b0; core_we = 1'b0; core_funct3 = 3'b0; core_addr = '0; core_wdata = '0;
    host_req_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wstrb = '0; host_wdata = '0;
    test_reset();
    test_core_directed();
    test_host();
    test_misalign();
    test_reset_midflight();
    test_contention();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
